// File: rtl/mbist_march_element_engine_if.sv
// Bundle of every signal that crosses between the March controller / SRAM side
// and the element engine.
//   slave  : the engine's view (commands and read data in, SRAM controls and
//            status out)
//   master : the controller / SRAM-model view (the mirror image)
// Command group : elem_start, elem_dir, elem_nops, elem_ops, abort, clr_fail
// SRAM group    : mem_addr, mem_we, mem_re, mem_wdata, mem_rdata
// Status group  : busy, elem_done, fail, fail_addr, fail_cnt
interface mbist_march_element_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  elem_start;
  logic                  elem_dir;
  logic [1:0]            elem_nops;
  logic [5:0]            elem_ops;
  logic                  abort;
  logic                  clr_fail;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  elem_done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [7:0]            fail_cnt;

  modport slave (
    input  elem_start, elem_dir, elem_nops, elem_ops, abort, clr_fail, mem_rdata,
    output mem_addr, mem_we, mem_re, mem_wdata, busy, elem_done,
           fail, fail_addr, fail_cnt
  );

  modport master (
    output elem_start, elem_dir, elem_nops, elem_ops, abort, clr_fail, mem_rdata,
    input  mem_addr, mem_we, mem_re, mem_wdata, busy, elem_done,
           fail, fail_addr, fail_cnt
  );
endinterface

// File: rtl/mbist_march_element_engine.sv
// Executes one March element (direction + up to three read/write ops per
// address) over addresses 0..ADDR_MAX, checking read data on the following
// cycle and keeping sticky fail status.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of mbist_march_element_engine_if (command, SRAM, status)
// All SRAM controls and status outputs are registered.
module mbist_march_element_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_MAX   = (2**ADDR_WIDTH)-1
) (
  input  logic                        clk,
  input  logic                        rst,
  mbist_march_element_engine_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_MAX);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [1:0]            nops_q, nops_d;
  logic [5:0]            ops_q, ops_d;
  // addr_q / idx_q identify the operation currently on the SRAM bus.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            idx_q, idx_d;

  // Compare pipeline: rd_exp_q belongs to the read on the bus this cycle,
  // cmp_* to the read whose data is arriving this cycle.
  logic                  rd_exp_q;
  logic                  cmp_valid_q;
  logic                  cmp_exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;

  logic [1:0]            op_d;
  logic                  issue_d;
  logic                  we_d, re_d, busy_d, done_d, exp_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [ADDR_WIDTH-1:0] maddr_d;
  logic                  mismatch;

  function automatic logic [1:0] op_at(input logic [5:0] ops, input logic [1:0] idx);
    case (idx)
      2'd0:    op_at = ops[1:0];
      2'd1:    op_at = ops[3:2];
      default: op_at = ops[5:4];
    endcase
  endfunction

  // State register, sweep counters, registered outputs and fail status.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers see
    // the pre-edge values of each other, independent of statement order.
    if (rst) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      nops_q        <= '0;
      ops_q         <= '0;
      addr_q        <= '0;
      idx_q         <= '0;
      rd_exp_q      <= 1'b0;
      cmp_valid_q   <= 1'b0;
      cmp_exp_q     <= 1'b0;
      cmp_addr_q    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.elem_done <= 1'b0;
      bus.fail      <= 1'b0;
      bus.fail_addr <= '0;
      bus.fail_cnt  <= '0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      nops_q        <= nops_d;
      ops_q         <= ops_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      rd_exp_q      <= exp_d;
      // A read issued in the cycle abort is seen is never compared.
      cmp_valid_q   <= bus.mem_re && !bus.abort;
      cmp_exp_q     <= rd_exp_q;
      cmp_addr_q    <= bus.mem_addr;
      bus.mem_addr  <= maddr_d;
      bus.mem_we    <= we_d;
      bus.mem_re    <= re_d;
      bus.mem_wdata <= wdata_d;
      bus.busy      <= busy_d;
      bus.elem_done <= done_d;
      if (bus.clr_fail) begin
        bus.fail      <= 1'b0;
        bus.fail_addr <= '0;
        bus.fail_cnt  <= '0;
      end else if (mismatch && !bus.abort) begin
        bus.fail <= 1'b1;
        if (!bus.fail) bus.fail_addr <= cmp_addr_q;
        if (bus.fail_cnt != 8'hFF) bus.fail_cnt <= bus.fail_cnt + 8'd1;
      end
    end
  end

  // Next state and sweep counters.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    dir_d   = dir_q;
    nops_d  = nops_q;
    ops_d   = ops_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.elem_start) begin
          if (bus.elem_nops != 2'd0) begin
            state_d = RUN;
            dir_d   = bus.elem_dir;
            nops_d  = bus.elem_nops;
            ops_d   = bus.elem_ops;
            addr_d  = bus.elem_dir ? ADDR_LAST : '0;
            idx_d   = 2'd0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (idx_q == nops_q - 2'd1) begin
          idx_d = 2'd0;
          // The counter stops at the final address instead of wrapping.
          if (addr_q == (dir_q ? '0 : ADDR_LAST)) state_d = DRAIN;
          else addr_d = dir_q ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Values the output registers take at the next edge, derived from the next
  // state so the first op appears the cycle after start is sampled.
  always_comb begin
    issue_d = (state_d == RUN);
    op_d    = op_at(ops_d, idx_d);
    we_d    = issue_d && op_d[1];
    re_d    = issue_d && !op_d[1];
    exp_d   = op_d[0];
    wdata_d = we_d ? {DATA_WIDTH{op_d[0]}} : bus.mem_wdata;
    maddr_d = issue_d ? addr_d : bus.mem_addr;
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    mismatch = cmp_valid_q && (bus.mem_rdata != {DATA_WIDTH{cmp_exp_q}});
  end

endmodule

// File: tb/tb_mbist_march_element_engine.sv
// Self-checking bench for mbist_march_element_engine (16-address memory).
// Expected SRAM operations are queued when an element is started and popped
// as the engine issues them; a behavioural SRAM answers reads one cycle later
// with optional single-bit corruption.
module tb_mbist_march_element_engine;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int AMAX = 15;

  localparam logic [5:0] OPS_W0    = 6'b000010;
  localparam logic [5:0] OPS_W1    = 6'b000011;
  localparam logic [5:0] OPS_R0    = 6'b000000;
  localparam logic [5:0] OPS_R0_W1 = 6'b001100;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbist_march_element_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mbist_march_element_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_MAX(AMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  op_t           exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] mem [AMAX+1];
  int            err_addr = -1;
  bit            err_all = 1'b0;

  // Behavioural SRAM: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re)
      bus.mem_rdata <= mem[bus.mem_addr] ^
                       ((err_all || int'(bus.mem_addr) == err_addr) ? 8'h01 : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_fail(input logic f, input logic [AW-1:0] a, input logic [7:0] c);
    check("fail", bus.fail, f);
    check("fail_addr", bus.fail_addr, a);
    check("fail_cnt", bus.fail_cnt, c);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_re"}, bus.mem_re, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_elem_done"}, bus.elem_done, 0);
    check_fail(1'b0, '0, 8'd0);
  endtask

  task automatic drive_start(input logic dir, input logic [1:0] nops, input logic [5:0] ops);
    @(negedge clk);
    bus.elem_start = 1'b1;
    bus.elem_dir   = dir;
    bus.elem_nops  = nops;
    bus.elem_ops   = ops;
  endtask

  task automatic push_elem(input logic dir, input logic [1:0] nops, input logic [5:0] ops);
    op_t        e;
    logic [1:0] op;
    for (int a = 0; a <= AMAX; a++) begin
      for (int i = 0; i < int'(nops); i++) begin
        op     = ops[2*i +: 2];
        e.cyc  = a * int'(nops) + i + 1;
        e.addr = dir ? AW'(AMAX - a) : AW'(a);
        e.we   = op[1];
        if (op[1]) last_wdata = {DW{op[0]}};
        e.wdata = last_wdata;
        exp_q.push_back(e);
      end
    end
  endtask

  // Runs one element; cycle n is sampled at the n-th falling edge after the
  // rising edge that sampled elem_start.
  task automatic run_elem(input logic dir, input logic [1:0] nops, input logic [5:0] ops);
    int  last;
    int  done_n;
    op_t e;
    last   = int'(nops) * (AMAX + 1);
    done_n = (nops == 2'd0) ? 1 : last + 2;
    push_elem(dir, nops, ops);
    drive_start(dir, nops, ops);
    for (int n = 1; n <= done_n + 1; n++) begin
      @(negedge clk);
      if (n == 1) bus.elem_start = 1'b0;
      check("busy", bus.busy, (nops != 2'd0) && (n <= last + 1));
      check("elem_done", bus.elem_done, n == done_n);
      if (bus.mem_we || bus.mem_re) begin
        if (exp_q.size() == 0) begin
          check("unexpected_op_cycle", n, 0);
        end else begin
          e = exp_q.pop_front();
          check("op_cycle", n, e.cyc);
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_we", bus.mem_we, e.we);
          check("mem_re", bus.mem_re, !e.we);
          check("mem_wdata", bus.mem_wdata, e.wdata);
        end
      end
    end
    check("ops_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.elem_start = 1'b0;
    bus.elem_dir   = 1'b0;
    bus.elem_nops  = 2'd0;
    bus.elem_ops   = 6'd0;
    bus.abort      = 1'b0;
    bus.clr_fail   = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Ascending w0, then descending r0,w1 against a clean memory.
    run_elem(1'b0, 2'd1, OPS_W0);
    run_elem(1'b1, 2'd2, OPS_R0_W1);
    check_fail(1'b0, '0, 8'd0);

    // Single corrupted read at address 9.
    run_elem(1'b0, 2'd1, OPS_W0);
    err_addr = 9;
    run_elem(1'b1, 2'd2, OPS_R0_W1);
    err_addr = -1;
    check_fail(1'b1, 4'd9, 8'd1);

    // Every read corrupted: count climbs then saturates, first address kept.
    run_elem(1'b0, 2'd1, OPS_W0);
    err_all = 1'b1;
    run_elem(1'b0, 2'd1, OPS_R0);
    check_fail(1'b1, 4'd9, 8'd17);
    repeat (18) run_elem(1'b0, 2'd1, OPS_R0);
    err_all = 1'b0;
    check_fail(1'b1, 4'd9, 8'd255);
    @(negedge clk);
    bus.clr_fail = 1'b1;
    @(negedge clk);
    bus.clr_fail = 1'b0;
    check_fail(1'b0, '0, 8'd0);

    // Abort in cycle 5 of a w0 sweep.
    drive_start(1'b0, 2'd1, OPS_W0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) bus.elem_start = 1'b0;
      check("abort_mem_we", bus.mem_we, n <= 5);
      check("abort_mem_re", bus.mem_re, 0);
      check("abort_busy", bus.busy, n <= 5);
      check("abort_elem_done", bus.elem_done, 0);
      if (n <= 5) check("abort_mem_addr", bus.mem_addr, n - 1);
      if (n == 5) bus.abort = 1'b1;
      if (n == 6) bus.abort = 1'b0;
    end
    run_elem(1'b0, 2'd1, OPS_W0);

    // Empty element: immediate done, no SRAM access.
    run_elem(1'b0, 2'd0, OPS_W0);
    check_fail(1'b0, '0, 8'd0);

    // Build some fail state, then reset in the middle of a w1 sweep.
    err_all = 1'b1;
    run_elem(1'b1, 2'd1, OPS_R0);
    err_all = 1'b0;
    check_fail(1'b1, 4'd15, 8'd16);
    drive_start(1'b0, 2'd1, OPS_W1);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) bus.elem_start = 1'b0;
    end
    check("midrun_mem_addr", bus.mem_addr, 3);
    check("midrun_mem_wdata", bus.mem_wdata, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mbist_march_element_engine.md
Name: mbist_march_element_engine

Overview:
- Executes one March element across the whole memory address space when commanded by the MBIST March controller.
- Element definition: direction plus up to 3 read/write operations per address.
- Drives SRAM address, write-enable, read-enable and write data each cycle, and compares read data against the expected value.
- Records fail status and pulses elem_done when the sweep completes. Sits between the March controller and the SRAM under test.

Parameters:
ADDR_WIDTH, 16, width of the SRAM address bus
DATA_WIDTH, 8, width of the SRAM data bus
ADDR_MAX, (2**ADDR_WIDTH)-1, highest address swept; the lowest address is always 0

Ports:
clk  input  1  the single clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
elem_start  input  1  one-cycle element start command; sampled only in IDLE
elem_dir  input  1  0 = ascending (0 to ADDR_MAX), 1 = descending (ADDR_MAX to 0); captured at start
elem_nops  input  2  number of operations per address, 1-3; 0 = empty element; captured at start
elem_ops  input  6  op i in bits [2i+1:2i]: bit1 = 1 write / 0 read, bit0 = data value (0 = all-zeros, 1 = all-ones); captured at start
abort  input  1  forces IDLE from any state
clr_fail  input  1  clears fail, fail_addr, fail_cnt
mem_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after mem_re
mem_addr  output  ADDR_WIDTH  SRAM address (registered)
mem_we  output  1  SRAM write enable (registered)
mem_re  output  1  SRAM read enable (registered)
mem_wdata  output  DATA_WIDTH  SRAM write data (registered)
busy  output  1  high while an element is executing
elem_done  output  1  one-cycle completion pulse
fail  output  1  sticky mismatch flag
fail_addr  output  ADDR_WIDTH  address of the first mismatch since the last clear
fail_cnt  output  8  mismatch count, saturates at 255

Behaviour:
- Reset (rst high at a rising edge): state IDLE; all outputs 0. This includes mem_addr, mem_wdata, fail_addr and fail_cnt. Reset overrides every other input.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - elem_start=1 with elem_nops≠0: capture dir/nops/ops, load the address counter (0 or ADDR_MAX), set op index to 0, go to RUN.
  - elem_start=1 with elem_nops=0: go to DONE with no memory access.
  - elem_start while not in IDLE is ignored.
- RUN: issues exactly one operation per cycle.
  - Operation issued: mem_addr = current address; mem_we / mem_re per op bit1; mem_wdata = all copies of op bit0.
  - mem_wdata is driven only on writes and holds its previous value on reads.
  - The op index advances 0 to nops-1. After the last op, the address steps by +1 or -1 and the op index returns to 0.
  - After the last op at the final address (ADDR_MAX ascending, 0 descending), go to DRAIN. The address counter never wraps.
- DRAIN: one cycle; mem_we = mem_re = 0; the final read data is compared. Then go to DONE.
- DONE: elem_done = 1 for exactly one cycle, busy = 0, then IDLE.
- Timing: if start is sampled at edge 0, the first op is visible in cycle 1.
  - Last op cycle L = nops*(ADDR_MAX+1).
  - busy is high in cycles 1 through L+1.
  - elem_done is high in cycle L+2.
  - An empty element gives elem_done in cycle 1 with busy never high.
- Compare pipeline:
  - When mem_re is issued in cycle k, expected data and address are registered.
  - mem_rdata is compared during cycle k+1.
  - On mismatch, fail/fail_cnt/fail_addr update visible in cycle k+2. fail_addr loads only when fail was 0.
  - Writes are never compared.
- clr_fail has priority over a same-cycle mismatch update. fail is otherwise sticky across elements.
- abort: next state IDLE; mem_we/mem_re 0 next cycle; no elem_done; pending compare discarded; fail state kept.
- abort has priority over elem_start in the same cycle.

Test Plan:
- ADDR_WIDTH=4, start dir=0, nops=1, ops=w0 -> mem_we high cycles 1-16, mem_addr 0..15, mem_wdata 0x00; busy cycles 1-17; elem_done at cycle 18.
- Then dir=1, nops=2, ops=r0,w1 with matching mem_rdata -> addr 15,15,14,14..0,0, alternating re/we, wdata 0xFF; fail stays 0; elem_done at cycle 34.
- Same element, model returns 0x01 only at the read of addr 9 -> fail=1, fail_addr=9, fail_cnt=1; elem_done still at cycle 34.
- Mismatch on every read of a 16-address r0 element after injecting 300 errors over repeats -> fail_cnt saturates at 255; clr_fail -> fail=0, fail_cnt=0, fail_addr=0.
- abort at cycle 5 of a w0 sweep -> mem_we 0 from cycle 6, busy 0, no elem_done; a new elem_start is accepted afterwards and the sweep starts at addr 0.
- elem_nops=0 -> elem_done at cycle 1, no mem_we/mem_re; rst asserted mid-RUN -> all outputs 0 the next cycle.
